// File: rtl/cpu_pkg.sv
// Shared fetch-side types and default constants.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Primary opcode of the MIPS-style j instruction.
  localparam logic [5:0]  OPCODE_J = 6'b000010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: branch > jump > stall > sequential.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc4_of_jump,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_index,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        flush
);

  logic [31:0] jump_pc;

  assign pc_plus4 = pc + 32'd4;
  // Jump target keeps the region bits of the jump's own PC+4.
  assign jump_pc  = (pc4_of_jump & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};

  // Select the next PC; a redirect always beats a stall.
  always_comb begin
    next_pc = pc_plus4;
    flush   = 1'b0;
    if (branch_taken) begin
      next_pc = branch_target & ~32'd3;
      flush   = 1'b1;
    end else if (jump_taken) begin
      next_pc = jump_pc;
      flush   = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM and IF/ID pipeline register.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_index,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] PC,
  output logic        InstrmemWr,
  input  logic [31:0] Instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_t state, state_nxt;
  logic         fetch_en;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         flush;

  next_pc_sel u_next_pc_sel (
    .pc            (PC),
    .pc4_of_jump   (if_id_pc4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_index    (jump_index),
    .stall         (stall),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .flush         (flush)
  );

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and read-enable decode; resume wins over halt_req in HALT.
  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        fetch_en = 1'b1;
        if (halt_req) state_nxt = HALT;
      end
      HALT: begin
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign InstrmemWr = fetch_en;

  // PC and IF/ID update; a halt request still lets the current cycle's PC update land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (state == RUN) begin
      PC <= next_pc;
      if (flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_instr <= Instr;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end
    end else if (state == HALT) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural fetch model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump_taken, halt_req, resume;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic        wr;
  logic [31:0] instr_bus;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;

  logic [31:0] rom [16];
  int          checks   = 0;
  int          failures = 0;
  bit          cmp_en   = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_index    (jump_index),
    .halt_req      (halt_req),
    .resume        (resume),
    .PC            (pc),
    .InstrmemWr    (wr),
    .Instr         (instr_bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  // 16-word combinational ROM, decoded on PC[5:2], zero when not enabled.
  assign instr_bus = wr ? rom[pc[5:2]] : 32'h0;

  // Behavioural model: mode 0 = dead cycle after reset, 1 = fetching, 2 = halted.
  typedef struct {
    int          mode;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_state();
    mstate_t r;
    r.mode = 0; r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s);
    mstate_t r = s;
    if (s.mode == 0) begin
      r.mode = 1;
    end else if (s.mode == 1) begin
      if (branch_taken) begin
        r.pc = {branch_target[31:2], 2'b00};
        r.instr = 32'h0; r.valid = 1'b0;
      end else if (jump_taken) begin
        r.pc = {s.pc4[31:28], jump_index, 2'b00};
        r.instr = 32'h0; r.valid = 1'b0;
      end else if (!stall) begin
        r.instr = rom[s.pc[5:2]];
        r.pc4   = s.pc + 32'd4;
        r.valid = 1'b1;
        r.pc    = s.pc + 32'd4;
      end
      if (halt_req) r.mode = 2;
    end else begin
      r.instr = 32'h0; r.valid = 1'b0;
      if (resume) r.mode = 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_state();
    else        m <= step(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc",    pc,          m.pc);
      chk("m_rd",    {31'b0, wr}, {31'b0, m.mode == 1});
      chk("m_instr", if_id_instr, m.instr);
      chk("m_pc4",   if_id_pc4,   m.pc4);
      chk("m_valid", {31'b0, if_id_valid}, {31'b0, m.valid});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; branch_taken = 0; jump_taken = 0; halt_req = 0; resume = 0;
    branch_target = '0; jump_index = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    for (int i = 0; i < 16; i++) rom[i] = {OPCODE_J, 6'(i), 16'($urandom), 4'(i)};
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Dead cycle, then sequential fetch from address 0.
    chk("idle_pc", pc, 32'h0);
    chk("idle_rd", {31'b0, wr}, 32'h0);
    chk("idle_valid", {31'b0, if_id_valid}, 32'h0);
    tick(); chk("run_pc0", pc, 32'h0); chk("run_rd", {31'b0, wr}, 32'h1);
    tick(); chk("seq_pc4", pc, 32'h4); chk("seq_i0", if_id_instr, rom[0]);
    chk("seq_v0", {31'b0, if_id_valid}, 32'h1); chk("seq_p0", if_id_pc4, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8); chk("seq_i1", if_id_instr, rom[1]);
    tick(); chk("seq_pcc", pc, 32'hC);

    // Fetch 0x3C, then jump with index 4 using if_id_pc4 = 0x40.
    branch_taken = 1; branch_target = 32'h3C;
    tick(); chk("br_pc3c", pc, 32'h3C); chk("br_flush", {31'b0, if_id_valid}, 32'h0);
    clear_in();
    tick(); chk("j_pc4", if_id_pc4, 32'h40); chk("j_i15", if_id_instr, rom[15]);
    jump_taken = 1; jump_index = 26'd4;
    tick(); chk("j_pc", pc, 32'h10); chk("j_flush", {31'b0, if_id_valid}, 32'h0);
    chk("j_nop", if_id_instr, 32'h0);
    clear_in();

    // Stall for three cycles at 0x14, then stall+branch to an unaligned target.
    tick(); chk("st_pc", pc, 32'h14);
    stall = 1;
    repeat (3) begin
      tick();
      chk("st_hold_pc", pc, 32'h14);
      chk("st_hold_i", if_id_instr, rom[4]);
      chk("st_hold_p", if_id_pc4, 32'h14);
    end
    branch_taken = 1; branch_target = 32'h2B;
    tick(); chk("stbr_pc", pc, 32'h28); chk("stbr_v", {31'b0, if_id_valid}, 32'h0);
    clear_in();

    // Halt and resume around PC 0x18.
    branch_taken = 1; branch_target = 32'h14;
    tick(); clear_in(); halt_req = 1;
    tick(); chk("h_pc", pc, 32'h18); chk("h_rd", {31'b0, wr}, 32'h0);
    halt_req = 0;
    tick(); chk("h_hold", pc, 32'h18); chk("h_v", {31'b0, if_id_valid}, 32'h0);
    resume = 1;
    tick(); chk("r_pc", pc, 32'h18); chk("r_rd", {31'b0, wr}, 32'h1);
    resume = 0;
    tick(); chk("r_i6", if_id_instr, rom[6]); chk("r_v", {31'b0, if_id_valid}, 32'h1);
    chk("r_pc1c", pc, 32'h1C);

    // Wrap from the top of the address space.
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    tick(); chk("w_top", pc, 32'hFFFF_FFFC);
    clear_in();
    tick(); chk("w_pc0", pc, 32'h0); chk("w_pc4", if_id_pc4, 32'h0);
    chk("w_i15", if_id_instr, rom[15]);

    // Asynchronous reset in the middle of a branch cycle.
    branch_taken = 1; branch_target = 32'h20;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc", pc, 32'h0); chk("ar_rd", {31'b0, wr}, 32'h0);
    chk("ar_v", {31'b0, if_id_valid}, 32'h0); chk("ar_i", if_id_instr, 32'h0);
    chk("ar_p", if_id_pc4, 32'h0);
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ar_idle", {31'b0, wr}, 32'h0);
    tick(); chk("ar_run", pc, 32'h0); chk("ar_rd1", {31'b0, wr}, 32'h1);
    tick(); chk("ar_seq", pc, 32'h4);

    // Randomised traffic checked by the model every cycle.
    repeat (1500) begin
      branch_taken  = ($urandom_range(0, 99) < 6);
      branch_target = $urandom;
      jump_taken    = ($urandom_range(0, 99) < 6);
      jump_index    = 26'($urandom);
      stall         = ($urandom_range(0, 99) < 15);
      halt_req      = ($urandom_range(0, 99) < 4);
      resume        = ($urandom_range(0, 99) < 30);
      tick();
    end
    clear_in();
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
